fib_encoder_param: RTL and testbench

Parametrised sequential binary-to-Fibonacci (Zeckendorf) encoder; successor to the fixed 16-to-32-bit ROM-based converter.
Fibonacci weights are generated on the fly by a down-stepping weight pair, so no weight memory is needed.
A per-transaction mode applies an LFSR-driven randomisation pass that rewrites digit patterns 100 to 011, producing a value-preserving, non-canonical encoding.
Adds input overflow detection and a busy/done handshake.

---
 rtl/fib_pkg.sv | 33 +++
 rtl/fib_lfsr16.sv | 34 +++
 rtl/fib_encoder_param.sv | 164 ++++++++++++++++
 tb/tb_fib_encoder_param.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared constants and types for the Fibonacci (Zeckendorf) encoder.
// Weights follow F(0)=1, F(1)=2, F(i)=F(i-1)+F(i-2).
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEDY = 2'd1,
        RAND   = 2'd2
    } fib_state_e;

    // Galois taps for x^16+x^14+x^13+x^11+1, right-shifting form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [63:0] fib(input int i);
        logic [63:0] p;
        logic [63:0] c;
        logic [63:0] t;
        p = 64'd1;
        c = 64'd2;
        if (i == 0) return p;
        for (int k = 2; k <= i; k++) begin
            t = c + p;
            p = c;
            c = t;
        end
        return c;
    endfunction

    function automatic logic [63:0] max_val(input int fib_w);
        return fib(fib_w) - 64'd1;
    endfunction

endpackage

// File: rtl/fib_lfsr16.sv
// 16-bit Galois LFSR; steps only when en_i is high.
// Only bit 0 is exported since that is all the randomiser consumes.
module fib_lfsr16
    import fib_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic bit_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_o = lfsr_q[0];

endmodule

// File: rtl/fib_encoder_param.sv
// Sequential binary-to-Fibonacci encoder: greedy digit pass, then an
// optional LFSR-driven 100->011 rewrite pass giving non-canonical codes.
module fib_encoder_param
    import fib_pkg::*;
#(
    parameter int          BIN_W     = 16,
    parameter int          FIB_W     = 32,
    parameter int          WGT_W     = 24,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             begin_b_f,
    input  logic             mode_rand,
    input  logic [BIN_W-1:0] input_bin,
    output logic [FIB_W-1:0] fibonacci_random,
    output logic             convert_done,
    output logic             conv_err,
    output logic             busy
);

    localparam int IDX_W = $clog2(FIB_W);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(FIB_W - 1);
    localparam logic [IDX_W-1:0] IDX_TWO = IDX_W'(2);
    localparam logic [WGT_W-1:0] MAX_VAL = WGT_W'(max_val(FIB_W));
    localparam logic [WGT_W-1:0] A_INIT  = WGT_W'(fib(FIB_W - 1));
    localparam logic [WGT_W-1:0] B_INIT  = WGT_W'(fib(FIB_W - 2));

    fib_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WGT_W-1:0] a_q, a_d;
    logic [WGT_W-1:0] b_q, b_d;
    logic [WGT_W-1:0] resid_q, resid_d;
    logic [FIB_W-1:0] digit_q, digit_d;
    logic [FIB_W-1:0] fib_q, fib_d;
    logic             mode_q, mode_d;
    logic             err_q, err_d;
    logic             cerr_q, cerr_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             finish;
    logic             lfsr_en;
    logic             lfsr_bit;
    logic [WGT_W-1:0] in_ext;
    logic             over;

    assign in_ext  = WGT_W'(input_bin);
    assign over    = in_ext > MAX_VAL;
    assign lfsr_en = (state_q == RAND);

    fib_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en_i  (lfsr_en),
        .bit_o (lfsr_bit)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        resid_d = resid_q;
        digit_d = digit_q;
        fib_d   = fib_q;
        mode_d  = mode_q;
        err_d   = err_q;
        cerr_d  = cerr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (begin_b_f) begin
                    resid_d = over ? '0 : in_ext;
                    mode_d  = mode_rand;
                    err_d   = over;
                    a_d     = A_INIT;
                    b_d     = B_INIT;
                    idx_d   = IDX_MAX;
                    digit_d = '0;
                    busy_d  = 1'b1;
                    cerr_d  = 1'b0;
                    state_d = GREEDY;
                end
            end
            GREEDY: begin
                if (resid_q >= a_q) begin
                    digit_d[idx_q] = 1'b1;
                    resid_d        = resid_q - a_q;
                end else begin
                    digit_d[idx_q] = 1'b0;
                end
                a_d   = b_q;
                b_d   = a_q - b_q;
                idx_d = idx_q - 1'b1;
                if (idx_q == '0) begin
                    if (mode_q) begin
                        state_d = RAND;
                        idx_d   = IDX_MAX;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            RAND: begin
                // F(i) = F(i-1) + F(i-2), so 100 -> 011 keeps the value
                if (digit_q[idx_q -: 3] == 3'b100 && lfsr_bit) begin
                    digit_d[idx_q -: 3] = 3'b011;
                end
                idx_d = idx_q - 1'b1;
                if (idx_q == IDX_TWO) begin
                    finish = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (finish) begin
            fib_d   = err_q ? '0 : digit_d;
            cerr_d  = err_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            resid_q <= '0;
            digit_q <= '0;
            fib_q   <= '0;
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
            cerr_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            resid_q <= resid_d;
            digit_q <= digit_d;
            fib_q   <= fib_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            cerr_q  <= cerr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign fibonacci_random = fib_q;
    assign convert_done     = done_q;
    assign conv_err         = cerr_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_fib_encoder_param.sv
// Directed bench for fib_encoder_param: default (FIB_W=32) and FIB_W=8
// instances sharing one clock and reset.
module tb_fib_encoder_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        bb  = 1'b0;
    logic        md  = 1'b0;
    logic [15:0] bin = '0;
    logic [31:0] res;
    logic        done, err, bsy;

    logic        b8   = 1'b0;
    logic        m8   = 1'b0;
    logic [15:0] bin8 = '0;
    logic [7:0]  res8;
    logic        done8, err8, bsy8;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    fib_encoder_param dut (
        .clk              (clk),
        .rst              (rst),
        .begin_b_f        (bb),
        .mode_rand        (md),
        .input_bin        (bin),
        .fibonacci_random (res),
        .convert_done     (done),
        .conv_err         (err),
        .busy             (bsy)
    );

    fib_encoder_param #(
        .FIB_W (8)
    ) dut8 (
        .clk              (clk),
        .rst              (rst),
        .begin_b_f        (b8),
        .mode_rand        (m8),
        .input_bin        (bin8),
        .fibonacci_random (res8),
        .convert_done     (done8),
        .conv_err         (err8),
        .busy             (bsy8)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Independent weight model: 1,2,3,5,8,...
    function automatic longint wsum(input logic [31:0] r, input int n);
        longint p, c, t, s;
        p = 1;
        c = 2;
        s = 0;
        for (int i = 0; i < n; i++) begin
            if (r[i]) s += (i == 0) ? p : c;
            if (i > 0) begin
                t = c + p;
                p = c;
                c = t;
            end
        end
        return s;
    endfunction

    task automatic wait_done(input bit sel, output int lat);
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if ((sel ? done8 : done) === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run(input bit sel, input logic [15:0] v,
                       input bit m, output int lat);
        @(negedge clk);
        if (sel) begin
            b8 = 1'b1; bin8 = v; m8 = m;
        end else begin
            bb = 1'b1; bin = v; md = m;
        end
        @(posedge clk);
        #1;
        bb = 1'b0;
        b8 = 1'b0;
        wait_done(sel, lat);
    endtask

    int          lat;
    int          nd;
    bit          found;
    logic [31:0] seen[$];

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res", res, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", bsy, 0);
        rst = 1'b1;

        run(0, 16'd0, 0, lat);
        chk("zero_lat", lat, 32);
        chk("zero_res", res, 0);
        chk("zero_err", err, 0);
        chk("zero_busy", bsy, 0);

        run(0, 16'd100, 0, lat);
        chk("c100_lat", lat, 32);
        chk("c100_res", res, 32'h00000214);

        run(0, 16'd65535, 0, lat);
        chk("cmax_res", res, 32'h00505204);
        chk("cmax_adj", res & (res >> 1), 0);
        chk("cmax_err", err, 0);

        run(1, 16'd54, 0, lat);
        chk("w8_54_lat", lat, 8);
        chk("w8_54_res", res8, 8'hAA);
        chk("w8_54_err", err8, 0);

        run(1, 16'd60, 0, lat);
        chk("w8_60_res", res8, 0);
        chk("w8_60_err", err8, 1);

        run(1, 16'd20, 0, lat);
        chk("w8_20_res", res8, 8'h2A);
        chk("w8_20_err", err8, 0);

        for (int r = 0; r < 1000; r++) begin
            run(0, 16'd100, 1, lat);
            chk("rand_lat", lat, 62);
            chk("rand_sum", wsum(res, 32), 100);
            found = 1'b0;
            foreach (seen[j]) if (seen[j] == res) found = 1'b1;
            if (!found) seen.push_back(res);
        end
        chk("rand_distinct", seen.size() >= 2, 1);

        // begin held high throughout: ignored while busy, taken on done cycle
        @(negedge clk);
        bb = 1'b1; bin = 16'd100; md = 1'b0;
        @(posedge clk);
        #1;
        bin = 16'd7;
        wait_done(0, lat);
        chk("b2b_lat1", lat, 32);
        chk("b2b_res1", res, 32'h00000214);
        @(posedge clk);
        #1;
        bb = 1'b0;
        chk("b2b_busy", bsy, 1);
        wait_done(0, lat);
        chk("b2b_lat2", lat, 32);
        chk("b2b_res2", res, 32'h0000000A);

        @(negedge clk);
        bb = 1'b1; bin = 16'd100; md = 1'b0;
        @(posedge clk);
        #1;
        bb = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("abort_res", res, 0);
        chk("abort_busy", bsy, 0);
        chk("abort_err", err, 0);
        nd = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        chk("abort_nodone", nd, 0);
        run(0, 16'd65535, 0, lat);
        chk("post_lat", lat, 32);
        chk("post_res", res, 32'h00505204);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
